uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. Captures each completed frame (`rx_frame` qualified by the one-cycle `rx_done` pulse) into a synchronous FIFO, drops frames flagged with `frame_error`, and counts them. Presents buffered bytes to the consumer over a first-word-fall-through valid/ready interface. Sticky overflow and error status are exposed for software or higher-level protocol logic.

## Interface
- `FRAME_WD`, default `` `FRAME_WD `` (8): frame data width; must match the receiver.
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `ERR_CNT_WD`, default 8: width of the saturating frame-error counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_frame`  in  FRAME_WD  received frame data from the UART receiver.
- `rx_done`  in  1  one-cycle pulse; `rx_frame` and `frame_error` are valid this cycle.
- `frame_error`  in  1  stop-bit/parity error for the current frame; ignored when `rx_done`=0.
- `m_data`  out  FRAME_WD  head-of-FIFO data; valid when `m_valid`=1, driven 0 when empty.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts `m_data`; a pop occurs when `m_valid && m_ready`.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky; a good frame was dropped because the FIFO was full.
- `err_cnt`  out  ERR_CNT_WD  count of frames dropped for `frame_error`; saturates at all-ones.
- `clr_status`  in  1  one-cycle clear of `overflow` and `err_cnt`.

## Operation
- push = `rx_done && !frame_error && (!full || pop)`; pop = `m_valid && m_ready`.
- A push writes `rx_frame` to `mem[wr_ptr]` and increments `wr_ptr`. A pop increments `rd_ptr`. Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
- `level` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: both occur, `level` stays DEPTH, and there is no overflow.
- Full with `rx_done && !frame_error && !pop`: frame is discarded, `overflow` is set, and the FIFO contents are untouched.
- `rx_done && frame_error`: no write; `err_cnt` increments by 1 unless it is already all-ones.
- `clr_status`: `overflow` ← 0, `err_cnt` ← 0. If an overflow or error event occurs in the same cycle, the event wins: `overflow` ← 1 or `err_cnt` ← 1.
- Empty with push in the same cycle: no pop can occur because `m_valid`=0. Data becomes visible on the next cycle.
- The consumer may hold `m_ready` high continuously. `m_data` must not change while `m_valid && !m_ready`.
- Reset, including mid-stream: `wr_ptr`=`rd_ptr`=0, `level`=0, `m_valid`=0, `full`=0, `m_data`=0, `overflow`=0, `err_cnt`=0. Memory contents are not reset. Inputs during the `rst` cycle are ignored.

## Timing
- Write-to-visible latency: 1 cycle. A frame pushed at edge N gives `m_valid`=1 and `m_data` = that frame after edge N.
- `m_data` is combinational from `mem[rd_ptr]`. `m_valid`, `full`, `level`, `overflow`, `err_cnt` are all registered or decoded directly from registered state.
- After a pop at edge N, the next entry is presented after edge N.
- Back-to-back `rx_done` on consecutive cycles must be supported, even though the receiver never produces them.
- Sustained throughput: 1 push and 1 pop per cycle.

## Structure
- Shared package `uart_pkg`: `FRAME_WD` and `DEPTH` defaults, plus `typedef logic [FRAME_WD-1:0] uart_frame_t`. This typedef is also used by the receiver and transmitter.
- One sub-module, `uart_fifo_mem`: DEPTH×FRAME_WD register array with a single write port and an asynchronous read port. Pointer, level and status logic live in `uart_rx_fifo`.

## Test plan
- Reset, then send 0x96 with `rx_done`=1 and `frame_error`=0, with `m_ready`=0. Next cycle: `m_valid`=1, `m_data`=0x96, `level`=1. Assert `m_ready` for one cycle: `m_valid`=0, `level`=0.
- Push 0x00..0x0F (16 frames) with `m_ready`=0: `full`=1, `level`=16. Push 0xAA: `overflow`=1 and `level` stays 16. Then drain: the sequence read is 0x00..0x0F, and 0xAA is absent.
- Full FIFO, push 0x55 and pop in the same cycle: `overflow` stays 0, `level`=16, and 0x55 is read last.
- Send 3 frames with `frame_error`=1: `err_cnt`=3 and `level`=0. Assert `clr_status` in the same cycle as a 4th error frame: `err_cnt`=1.
- With `ERR_CNT_WD`=2, send 5 error frames: `err_cnt`=3 (saturated).
- Push 5 frames, assert `rst` for one cycle: all outputs return to reset values. Push 0x3C: it reads back as 0x3C with `level`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the
// receive FIFO.
//   DEF_FRAME_WD : default frame data width (overridable with `FRAME_WD)
//   DEF_DEPTH    : default receive FIFO depth
//   uart_frame_t : one frame of UART data
`ifndef FRAME_WD
`define FRAME_WD 8
`endif

package uart_pkg;
  localparam int DEF_FRAME_WD = `FRAME_WD;
  localparam int DEF_DEPTH    = 16;

  typedef logic [DEF_FRAME_WD-1:0] uart_frame_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side stream of the receive FIFO.
//   m_data  : head-of-FIFO data, 0 when m_valid is low
//   m_valid : FIFO holds at least one entry
//   m_ready : consumer accepts m_data
// Handshake: a transfer happens on every rising edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_data holds its value. m_valid
// never depends on m_ready, and the consumer may keep m_ready high.
// Modports: master = the FIFO (drives data/valid), slave = the consumer.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int FRAME_WD = DEF_FRAME_WD
);
  logic [FRAME_WD-1:0] m_data;
  logic                m_valid;
  logic                m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array of the receive FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module uart_fifo_mem import uart_pkg::*; #(
  parameter int FRAME_WD = DEF_FRAME_WD,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [FRAME_WD-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [FRAME_WD-1:0]      rdata_o
);
  logic [FRAME_WD-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Good frames are written to a
// first-word-fall-through FIFO, frames with a frame error are dropped and
// counted, and a good frame arriving while the FIFO is full and not being
// popped is dropped and flagged as overflow.
//   clk, rst    : clock, synchronous active-high reset
//   rx_frame    : received frame data
//   rx_done     : one-cycle strobe qualifying rx_frame / frame_error
//   frame_error : frame error for the current frame
//   m_if        : consumer stream (m_data / m_valid / m_ready)
//   level       : occupancy 0..DEPTH
//   full        : level == DEPTH
//   overflow    : sticky, good frame dropped because FIFO was full
//   err_cnt     : saturating count of frames dropped for frame_error
//   clr_status  : clears overflow and err_cnt (same-cycle events win)
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int FRAME_WD   = DEF_FRAME_WD,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ERR_CNT_WD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_WD-1:0]      rx_frame,
  input  logic                     rx_done,
  input  logic                     frame_error,
  uart_rx_fifo_if.master           m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [ERR_CNT_WD-1:0]    err_cnt,
  input  logic                     clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic [ERR_CNT_WD-1:0] err_cnt_q;

  logic                  good_frame, err_frame, push, pop, ovf_evt;
  logic                  empty;
  logic [FRAME_WD-1:0]   rd_data;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LW'(DEPTH));
  assign good_frame = rx_done && !frame_error;
  assign err_frame  = rx_done && frame_error;
  assign pop        = !empty && m_if.m_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign push       = good_frame && (!full || pop);
  assign ovf_evt    = good_frame && full && !pop;

  uart_fifo_mem #(
    .FRAME_WD (FRAME_WD),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_frame),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);

      // Events take priority over a simultaneous clear.
      if (ovf_evt)         overflow_q <= 1'b1;
      else if (clr_status) overflow_q <= 1'b0;

      if (err_frame) begin
        if (clr_status)           err_cnt_q <= ERR_CNT_WD'(1);
        else if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_WD'(1);
      end else if (clr_status) begin
        err_cnt_q <= '0;
      end
    end
  end

  // Unwritten memory may hold anything; present zero whenever empty.
  assign m_if.m_valid = !empty;
  assign m_if.m_data  = empty ? '0 : rd_data;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults ----------------
  uart_rx_fifo_if #(.FRAME_WD(8)) ifa ();
  uart_frame_t rx_frame;
  logic        rx_done, frame_error, clr_status;
  logic [4:0]  level;
  logic        full, overflow;
  logic [7:0]  err_cnt;

  uart_rx_fifo #(.FRAME_WD(8), .DEPTH(16), .ERR_CNT_WD(8)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .rx_frame    (rx_frame),
    .rx_done     (rx_done),
    .frame_error (frame_error),
    .m_if        (ifa.master),
    .level       (level),
    .full        (full),
    .overflow    (overflow),
    .err_cnt     (err_cnt),
    .clr_status  (clr_status)
  );

  // ---------------- DUT B: 2-bit error counter ----------------
  uart_rx_fifo_if #(.FRAME_WD(8)) ifb ();
  logic        rx_done_b, frame_error_b;
  logic [4:0]  level_b;
  logic        full_b, overflow_b;
  logic [1:0]  err_cnt_b;

  uart_rx_fifo #(.FRAME_WD(8), .DEPTH(16), .ERR_CNT_WD(2)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .rx_frame    (rx_frame),
    .rx_done     (rx_done_b),
    .frame_error (frame_error_b),
    .m_if        (ifb.master),
    .level       (level_b),
    .full        (full_b),
    .overflow    (overflow_b),
    .err_cnt     (err_cnt_b),
    .clr_status  (1'b0)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] data, input logic ferr);
    rx_frame    = data;
    rx_done     = 1'b1;
    frame_error = ferr;
    tick();
    rx_done     = 1'b0;
    frame_error = 1'b0;
  endtask

  // Pop everything in exp_q, checking each head before its pop edge.
  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    ifa.m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(ifa.m_data), 32'(exp_q.pop_front()));
      tick();
    end
    ifa.m_ready = 1'b0;
    check({tag, "_empty"}, 32'(level), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; rx_frame = '0; rx_done = 1'b0; frame_error = 1'b0;
    clr_status = 1'b0; ifa.m_ready = 1'b0; ifb.m_ready = 1'b0;
    rx_done_b = 1'b0; frame_error_b = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", 32'(ifa.m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", 32'(ifa.m_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_err_b", 32'(err_cnt_b), 32'd0);

    // single frame, visible one edge later, then popped
    send(8'h96, 1'b0);
    check("t1_valid", 32'(ifa.m_valid), 32'd1);
    check("t1_data", 32'(ifa.m_data), 32'h96);
    check("t1_level", 32'(level), 32'd1);
    ifa.m_ready = 1'b1;
    tick();
    ifa.m_ready = 1'b0;
    check("t1_pop_valid", 32'(ifa.m_valid), 32'd0);
    check("t1_pop_level", 32'(level), 32'd0);
    check("t1_pop_data", 32'(ifa.m_data), 32'd0);

    // fill to full, overflow drops 0xAA
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      exp_q.push_back(8'(i));
    end
    check("t2_full", 32'(full), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    check("t2_ovf0", 32'(overflow), 32'd0);
    send(8'hAA, 1'b0);
    check("t2_ovf1", 32'(overflow), 32'd1);
    check("t2_level_ovf", 32'(level), 32'd16);
    tick();
    check("t2_hold_data", 32'(ifa.m_data), 32'h00);
    drain("t2_drain");
    check("t2_ovf_sticky", 32'(overflow), 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h10 + i), 1'b0);
      exp_q.push_back(8'(8'h10 + i));
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_head", 32'(ifa.m_data), 32'h10);
    ifa.m_ready = 1'b1;
    void'(exp_q.pop_front());
    send(8'h55, 1'b0);
    exp_q.push_back(8'h55);
    ifa.m_ready = 1'b0;
    check("t3_ovf", 32'(overflow), 32'd0);
    check("t3_level", 32'(level), 32'd16);
    check("t3_full2", 32'(full), 32'd1);
    drain("t3_drain");

    // error frames, back to back, then clear colliding with a 4th error
    send(8'hEE, 1'b1);
    send(8'hEE, 1'b1);
    send(8'hEE, 1'b1);
    check("t4_err3", 32'(err_cnt), 32'd3);
    check("t4_level", 32'(level), 32'd0);
    check("t4_valid", 32'(ifa.m_valid), 32'd0);
    clr_status = 1'b1;
    send(8'hEE, 1'b1);
    clr_status = 1'b0;
    check("t4_clr_evt", 32'(err_cnt), 32'd1);

    // saturation with a 2-bit counter
    rx_done_b = 1'b1; frame_error_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rx_done_b = 1'b0; frame_error_b = 1'b0;
    check("t5_sat", 32'(err_cnt_b), 32'd3);
    check("t5_level_b", 32'(level_b), 32'd0);

    // empty push with m_ready held high, then one-in/one-out streaming
    ifa.m_ready = 1'b1;
    send(8'h42, 1'b0);
    check("t6_fwft_data", 32'(ifa.m_data), 32'h42);
    check("t6_fwft_level", 32'(level), 32'd1);
    send(8'h61, 1'b0);
    check("t6_stream_data", 32'(ifa.m_data), 32'h61);
    check("t6_stream_level", 32'(level), 32'd1);
    tick();
    ifa.m_ready = 1'b0;
    check("t6_stream_empty", 32'(level), 32'd0);

    // mid-stream reset; inputs during reset are ignored
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    check("t7_level5", 32'(level), 32'd5);
    rst = 1'b1; rx_frame = 8'h77; rx_done = 1'b1; frame_error = 1'b1;
    tick();
    rst = 1'b0; rx_done = 1'b0; frame_error = 1'b0;
    check("t7_rst_level", 32'(level), 32'd0);
    check("t7_rst_valid", 32'(ifa.m_valid), 32'd0);
    check("t7_rst_data", 32'(ifa.m_data), 32'd0);
    check("t7_rst_full", 32'(full), 32'd0);
    check("t7_rst_err", 32'(err_cnt), 32'd0);
    check("t7_rst_ovf", 32'(overflow), 32'd0);
    check("t7_rst_err_b", 32'(err_cnt_b), 32'd0);
    send(8'h3C, 1'b0);
    check("t7_data", 32'(ifa.m_data), 32'h3C);
    check("t7_level", 32'(level), 32'd1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
